// File: rtl/axi_w_fifo_drain.sv
// Drains {data,strb,last} entries from the W clock-crossing FIFO onto an AXI4 W channel.
// WLAST comes from a beat counter; the FIFO last bit is only cross-checked.
module axi_w_fifo_drain #(
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int ENTRY_W = DATA_W + STRB_W + 1,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_not_empty,
    output logic               fifo_rd_en,
    input  logic [ENTRY_W-1:0] fifo_r_data,
    input  logic               len_valid,
    output logic               len_ready,
    input  logic [LEN_W-1:0]   len,
    output logic [DATA_W-1:0]  WDATA,
    output logic [STRB_W-1:0]  WSTRB,
    output logic               WLAST,
    output logic               WVALID,
    input  logic               WREADY,
    output logic               burst_done,
    output logic               err_last
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [LEN_W-1:0]   sent_cnt_q, sent_cnt_d;
    logic               pops_done_q, pops_done_d;
    logic               err_q, err_d;
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [1:0]         count_q, count_d;
    logic [DATA_W-1:0]  bdata_q [2];
    logic [DATA_W-1:0]  bdata_d [2];
    logic [STRB_W-1:0]  bstrb_q [2];
    logic [STRB_W-1:0]  bstrb_d [2];

    logic               pop;
    logic               accept;
    logic               len_fire;
    logic               last_pop;

    // Pop decision deliberately ignores WREADY; the 2-deep buffer absorbs the stall.
    always_comb begin
        len_ready  = (state_q == S_IDLE) && !rst;
        len_fire   = len_valid && len_ready;
        fifo_rd_en = (state_q == S_XFER) && fifo_not_empty && (count_q < 2'd2)
                     && !pops_done_q && !rst;
        pop        = fifo_rd_en;
        last_pop   = (pop_cnt_q == len_q);
        WVALID     = (count_q != 2'd0);
        WDATA      = bdata_q[head_q];
        WSTRB      = bstrb_q[head_q];
        WLAST      = WVALID && (sent_cnt_q == len_q);
        accept     = WVALID && WREADY;
        burst_done = accept && WLAST;
        err_last   = err_q;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pop_cnt_d   = pop_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        pops_done_d = pops_done_q;
        err_d       = err_q;
        head_d      = head_q;
        tail_d      = tail_q;
        bdata_d     = bdata_q;
        bstrb_d     = bstrb_q;
        count_d     = count_q + {1'b0, pop} - {1'b0, accept};

        if (len_fire) begin
            state_d     = S_XFER;
            len_d       = len;
            pop_cnt_d   = '0;
            sent_cnt_d  = '0;
            pops_done_d = 1'b0;
        end

        if (pop) begin
            bdata_d[tail_q] = fifo_r_data[ENTRY_W-1:STRB_W+1];
            bstrb_d[tail_q] = fifo_r_data[STRB_W:1];
            tail_d          = ~tail_q;
            pop_cnt_d       = pop_cnt_q + 1'b1;
            if (last_pop) begin
                pops_done_d = 1'b1;
            end
            if (fifo_r_data[0] != last_pop) begin
                err_d = 1'b1;
            end
        end

        if (accept) begin
            head_d     = ~head_q;
            sent_cnt_d = sent_cnt_q + 1'b1;
            if (WLAST) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pop_cnt_q   <= '0;
            sent_cnt_q  <= '0;
            pops_done_q <= 1'b0;
            err_q       <= 1'b0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            bdata_q[0]  <= '0;
            bdata_q[1]  <= '0;
            bstrb_q[0]  <= '0;
            bstrb_q[1]  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pop_cnt_q   <= pop_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            pops_done_q <= pops_done_d;
            err_q       <= err_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            bdata_q[0]  <= bdata_d[0];
            bdata_q[1]  <= bdata_d[1];
            bstrb_q[0]  <= bstrb_d[0];
            bstrb_q[1]  <= bstrb_d[1];
        end
    end

endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// Bench for axi_w_fifo_drain: an ideal FIFO model feeds bursts, a negedge monitor
// collects accepted W beats, and each burst is compared against its generated entry list.
module tb_axi_w_fifo_drain;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int ENTRY_W = 37;
    localparam int LEN_W   = 8;
    localparam int DEPTH   = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fifo_not_empty;
    logic               fifo_rd_en;
    logic [ENTRY_W-1:0] fifo_r_data;
    logic               len_valid = 1'b0;
    logic               len_ready;
    logic [LEN_W-1:0]   len = '0;
    logic [DATA_W-1:0]  WDATA;
    logic [STRB_W-1:0]  WSTRB;
    logic               WLAST;
    logic               WVALID;
    logic               WREADY = 1'b0;
    logic               burst_done;
    logic               err_last;

    axi_w_fifo_drain #(
        .DATA_W(DATA_W), .STRB_W(STRB_W), .ENTRY_W(ENTRY_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_not_empty(fifo_not_empty), .fifo_rd_en(fifo_rd_en), .fifo_r_data(fifo_r_data),
        .len_valid(len_valid), .len_ready(len_ready), .len(len),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .burst_done(burst_done), .err_last(err_last)
    );

    always #5 clk = ~clk;

    // Ideal source FIFO: entries stay in fmem, frd advances on each pop.
    logic [ENTRY_W-1:0] fmem [DEPTH];
    int fwr = 0;
    int frd = 0;
    int cyc = 0;
    assign fifo_not_empty = (fwr != frd);
    assign fifo_r_data    = (fifo_rd_en && fifo_not_empty) ? fmem[frd % DEPTH] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_not_empty) frd <= frd + 1;
    end

    logic [ENTRY_W-1:0] beats[$];
    int                 beat_cyc[$];
    int                 pop_cyc[$];
    int                 done_cnt = 0;
    int                 stab_err = 0;
    logic               prev_hold = 1'b0;
    logic [ENTRY_W-1:0] prev_beat = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold && !(WVALID && {WDATA, WSTRB, WLAST} == prev_beat))
                stab_err <= stab_err + 1;
            if (WVALID && WREADY) begin
                beats.push_back({WDATA, WSTRB, WLAST});
                beat_cyc.push_back(cyc);
            end
            if (fifo_rd_en && fifo_not_empty) pop_cyc.push_back(cyc);
            if (burst_done) done_cnt <= done_cnt + 1;
            prev_hold <= WVALID && !WREADY;
            prev_beat <= {WDATA, WSTRB, WLAST};
        end else begin
            prev_hold <= 1'b0;
        end
    end

    int   total = 0;
    int   bad = 0;
    logic err_model = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ENTRY_W-1:0] e);
        fmem[fwr % DEPTH] = e;
        fwr = fwr + 1;
    endtask

    task automatic send_len(input int l);
        bit ok = 1'b0;
        len       = l[LEN_W-1:0];
        len_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (len_ready) ok = 1'b1;
            step();
        end
        len_valid = 1'b0;
        chk("len_handshake", {63'd0, ok}, 64'd1);
    endtask

    // rmode: 0 WREADY always high, 1 toggling, 2 random.
    // The first prefill entries are loaded up front; the rest arrive from cycle gap on.
    task automatic run_burst(input string tag, input int l, input int bad_idx,
                             input int rmode, input int prefill, input int gap);
        logic [ENTRY_W-1:0] ent[$];
        logic [ENTRY_W-1:0] expq[$];
        logic [DATA_W-1:0]  d;
        logic [STRB_W-1:0]  s;
        logic               lst;
        int n      = l + 1;
        int pushed = 0;
        int base   = beats.size();
        int d0     = done_cnt;
        int p0     = pop_cyc.size();
        int c      = 0;
        for (int i = 0; i < n; i++) begin
            d   = $urandom;
            s   = STRB_W'($urandom_range(1, 15));
            lst = (i == l) ^ (i == bad_idx);
            ent.push_back({d, s, lst});
            expq.push_back({d, s, (i == l)});
            if (lst != (i == l)) err_model = 1'b1;
        end
        while (pushed < prefill && pushed < n) begin
            push(ent[pushed]);
            pushed++;
        end
        WREADY = 1'b1;
        send_len(l);
        while (beats.size() < base + n && c < 8 * n + 100) begin
            case (rmode)
                0:       WREADY = 1'b1;
                1:       WREADY = (c % 2 == 0);
                default: WREADY = 1'($urandom_range(0, 1));
            endcase
            if (pushed < n && c >= gap && (rmode != 2 || $urandom_range(0, 2) != 0)) begin
                push(ent[pushed]);
                pushed++;
            end
            step();
            c++;
        end
        step();
        chk({tag, "_nbeats"}, 64'(beats.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < beats.size(); i++)
            chk({tag, "_beat"}, 64'(beats[base + i]), 64'(expq[i]));
        chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_pops"}, 64'(pop_cyc.size() - p0), 64'(n));
        chk({tag, "_err"}, {63'd0, err_last}, {63'd0, err_model});
    endtask

    initial begin
        int                 b;
        int                 p;
        int                 d0;
        int                 c;
        logic [ENTRY_W-1:0] e;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_wvalid", {63'd0, WVALID}, 64'd0);
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_err", {63'd0, err_last}, 64'd0);
        chk("rst_len_ready", {63'd0, len_ready}, 64'd0);
        chk("rst_wlast", {63'd0, WLAST}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_len_ready", {63'd0, len_ready}, 64'd1);
        step();

        // Preloaded 4-beat burst at full rate
        b = beats.size();
        p = pop_cyc.size();
        run_burst("t2", 3, -1, 0, 4, 0);
        chk("t2_contig", (beats.size() >= b + 4) ? 64'(beat_cyc[b+3] - beat_cyc[b]) : '1, 64'd3);
        chk("t2_latency", (beats.size() > b && pop_cyc.size() > p) ?
            64'(beat_cyc[b] - pop_cyc[p]) : '1, 64'd1);

        // Single beat held under WREADY low
        b  = beats.size();
        p  = pop_cyc.size();
        d0 = done_cnt;
        WREADY = 1'b0;
        e = {32'($urandom), 4'hF, 1'b1};
        push(e);
        send_len(0);
        WREADY = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("t3_wvalid", {63'd0, WVALID}, 64'd1);
        chk("t3_held", 64'({WDATA, WSTRB, WLAST}), 64'(e));
        chk("t3_stable", 64'(stab_err), 64'd0);
        chk("t3_one_pop", 64'(pop_cyc.size() - p), 64'd1);
        chk("t3_no_beat", 64'(beats.size() - b), 64'd0);
        @(posedge clk);
        #1 WREADY = 1'b1;
        step();
        @(negedge clk);
        chk("t3_idle", {63'd0, len_ready}, 64'd1);
        chk("t3_beat", (beats.size() > b) ? 64'(beats[b]) : '1, 64'(e));
        chk("t3_done", 64'(done_cnt - d0), 64'd1);
        chk("t3_empty", {63'd0, WVALID}, 64'd0);
        step();

        // Toggling WREADY with the FIFO running dry mid-burst
        run_burst("t4", 7, -1, 1, 3, 6);

        // Random bursts with well-formed last bits
        for (int k = 0; k < 4; k++) begin
            c = $urandom_range(0, 20);
            run_burst("rnd", c, -1, 2, $urandom_range(0, c + 1), $urandom_range(0, 5));
        end

        // Corrupt last bit on beat 0, then confirm the flag is sticky
        run_burst("t5", 1, 0, 0, 2, 0);
        run_burst("t5_sticky", 2, -1, 2, 1, 2);

        // Maximum-length burst must run to 256 beats
        run_burst("t256", 255, -1, 0, 256, 0);

        // Reset in the middle of a long burst
        for (int i = 0; i < 256; i++) push({32'($urandom), 4'hF, 1'(i == 255)});
        WREADY = 1'b1;
        b = beats.size();
        send_len(255);
        c = 0;
        while (beats.size() < b + 100 && c < 400) begin
            step();
            c++;
        end
        chk("t6_reach_100", {63'd0, (beats.size() >= b + 100)}, 64'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t6_wvalid", {63'd0, WVALID}, 64'd0);
        chk("t6_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("t6_len_ready_rst", {63'd0, len_ready}, 64'd0);
        chk("t6_err_clr", {63'd0, err_last}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        fwr = frd;
        err_model = 1'b0;
        @(negedge clk);
        chk("t6_idle", {63'd0, len_ready}, 64'd1);
        chk("t6_wvalid_after", {63'd0, WVALID}, 64'd0);
        step();
        run_burst("t6_post", 2, -1, 0, 3, 0);

        chk("stability", 64'(stab_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
